// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared run/step controller state encodings
package cpu_run_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// rtl/cpu_run_ctrl_btn_debounce.sv - push-button synchroniser, debounce and rising-edge pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk_100M,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stable_cnt;

    // stable_cnt counts consecutive samples that disagree with the accepted level
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= din;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level      <= sync2;
                stable_cnt <= '0;
                rise_pulse <= sync2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - RUN/STEP/HALT controller turning clk_1M rises into cpu_en pulses
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 32
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             clk_1M,
    input  logic             btn_step,
    input  logic             sw_run,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [1:0]       run_state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    logic       run_m;
    logic       run_s;
    logic       clk_1M_d;
    logic       tick;
    logic       btn_db;
    logic       btn_rise;
    logic       step_req;
    logic [1:0] state;
    logic [1:0] state_nx;
    logic       fire;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk_100M  (clk_100M),
        .rst_n     (rst_n),
        .din       (btn_step),
        .level     (btn_db),
        .rise_pulse(btn_rise)
    );

    assign step_req = btn_rise & btn_db;
    assign tick     = clk_1M & ~clk_1M_d;

    always_comb begin
        state_nx = state;
        fire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_s)         state_nx = ST_RUN;
                else if (step_req) state_nx = ST_STEP;
            end
            ST_RUN: begin
                if (halt_req)      state_nx = ST_HALT;
                else if (!run_s)   state_nx = ST_IDLE;
                else if (tick)     fire     = 1'b1;
            end
            ST_STEP: begin
                if (halt_req) begin
                    state_nx = ST_HALT;
                end else if (tick) begin
                    fire     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                if (!run_s)        state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            run_m     <= 1'b0;
            run_s     <= 1'b0;
            clk_1M_d  <= 1'b0;
            state     <= ST_IDLE;
            cpu_en    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            run_m    <= sw_run;
            run_s    <= run_m;
            clk_1M_d <= clk_1M;
            state    <= state_nx;
            cpu_en   <= fire;
            if (fire) instr_cnt <= instr_cnt + 1'b1;
        end
    end

    assign run_state = state;
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl against a behavioural model
module tb_cpu_run_ctrl;

    localparam int DB  = 4;
    localparam int CW  = 4;
    localparam int PER = 101;

    logic          clk_100M = 1'b0;
    logic          rst_n;
    logic          clk_1M;
    logic          btn_step;
    logic          sw_run;
    logic          halt_req;
    logic          cpu_en;
    logic [1:0]    run_state;
    logic          halted;
    logic [CW-1:0] instr_cnt;

    cpu_run_ctrl #(.DEBOUNCE_CYC(DB), .CNT_W(CW)) dut (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .clk_1M   (clk_1M),
        .btn_step (btn_step),
        .sw_run   (sw_run),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .run_state(run_state),
        .halted   (halted),
        .instr_cnt(instr_cnt)
    );

    always #5 clk_100M = ~clk_100M;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int ph     = 1;
    bit sw_v, btn_v, halt_v;

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
    int m_state;
    bit m_en;
    int m_cnt;
    bit m_level;
    bit m_pend;
    bit q_sw[$];
    bit q_btn[$];
    bit q_clk[$];

    typedef struct {
        bit sw;
        bit btn;
        bit halt;
        int cycles;
        int exp_state;
        bit exp_halted;
    } row_t;
    row_t rows[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_en = 0; m_cnt = 0; m_level = 0; m_pend = 0;
        q_sw.delete(); q_btn.delete(); q_clk.delete();
        for (int i = 0; i < 8; i++) begin
            q_sw.push_back(0); q_btn.push_back(0); q_clk.push_back(0);
        end
    endtask

    // Synchronised inputs are the raw samples from two edges earlier
    task automatic model_edge(input bit sw, input bit btn, input bit halt, input bit c1m);
        int n;
        bit run_s, tick, step_req, flip, fire;
        q_sw.push_back(sw); q_btn.push_back(btn); q_clk.push_back(c1m);
        if (q_sw.size() > 16) begin
            void'(q_sw.pop_front()); void'(q_btn.pop_front()); void'(q_clk.pop_front());
        end
        n        = q_sw.size();
        run_s    = q_sw[n-3];
        tick     = q_clk[n-1] && !q_clk[n-2];
        step_req = m_pend;
        m_pend   = 0;
        flip = 1;
        for (int i = 0; i < DB; i++) if (q_btn[n-3-i] == m_level) flip = 0;
        if (flip) begin
            m_level = !m_level;
            if (m_level) m_pend = 1;
        end
        fire = 0;
        case (m_state)
            M_IDLE: if (run_s) m_state = M_RUN; else if (step_req) m_state = M_STEP;
            M_RUN:  if (halt) m_state = M_HALT; else if (!run_s) m_state = M_IDLE; else if (tick) fire = 1;
            M_STEP: if (halt) m_state = M_HALT; else if (tick) begin fire = 1; m_state = M_IDLE; end
            default: if (!run_s) m_state = M_IDLE;
        endcase
        m_en = fire;
        if (fire) m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic cyc();
        @(negedge clk_100M);
        sw_run = sw_v; btn_step = btn_v; halt_req = halt_v;
        clk_1M = (ph == 0);
        ph = (ph + 1) % PER;
        @(posedge clk_100M);
        model_edge(sw_v, btn_v, halt_v, clk_1M);
        #1;
        check("cpu_en", cpu_en, m_en);
        check("run_state", run_state, m_state);
        check("halted", halted, m_state == M_HALT);
        check("instr_cnt", instr_cnt, m_cnt);
        if (cpu_en === 1'b1) pulses++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic align(input int target);
        while (ph != target) cyc();
    endtask

    task automatic reset_now();
        rst_n = 0;
        model_reset();
        #1;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_state", run_state, 0);
        check("rst_halted", halted, 0);
        check("rst_cnt", instr_cnt, 0);
        @(posedge clk_100M);
        #2 rst_n = 1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int p0, c0, s;
        bit found;
        rows[0] = '{0, 0, 0, 20,  M_IDLE, 0};
        rows[1] = '{1, 0, 0, 5,   M_RUN,  0};
        rows[2] = '{1, 0, 1, 3,   M_HALT, 1};
        rows[3] = '{1, 1, 0, 200, M_HALT, 1};
        rows[4] = '{0, 0, 0, 2,   M_HALT, 1};
        rows[5] = '{0, 0, 0, 10,  M_IDLE, 0};
        rows[6] = '{0, 1, 0, 300, M_IDLE, 0};
        rows[7] = '{0, 0, 1, 20,  M_IDLE, 0};
        rows[8] = '{1, 0, 1, 4,   M_HALT, 1};
        rows[9] = '{0, 0, 0, 10,  M_IDLE, 0};

        clk_1M = 0; btn_step = 0; sw_run = 0; halt_req = 0;
        sw_v = 0; btn_v = 0; halt_v = 0;
        reset_now();

        for (int r = 0; r < 10; r++) begin
            sw_v = rows[r].sw; btn_v = rows[r].btn; halt_v = rows[r].halt;
            run(rows[r].cycles);
            check($sformatf("tbl%0d_state", r), run_state, rows[r].exp_state);
            check($sformatf("tbl%0d_halted", r), halted, rows[r].exp_halted);
        end
        sw_v = 0; btn_v = 0; halt_v = 0;

        // Free-run: first tick lands on the 10th edge after sw_run rises
        align(92);
        sw_v = 1; p0 = pulses; c0 = m_cnt;
        run(3);
        check("freerun_state_after_3", run_state, M_RUN);
        run(1007);
        check("freerun_pulses", pulses - p0, 10);
        check("freerun_cnt", instr_cnt, (c0 + 10) % 16);

        // Run-off race: run_s falls on the tick edge
        align(99);
        sw_v = 0; p0 = pulses;
        run(3);
        check("runoff_state", run_state, M_IDLE);
        run(5);
        check("runoff_pulses", pulses - p0, 0);

        // Halt arriving together with a tick
        sw_v = 1;
        run(5);
        align(0);
        halt_v = 1; p0 = pulses;
        run(1);
        check("halt_tick_en", cpu_en, 0);
        check("halt_tick_state", run_state, M_HALT);
        check("halt_tick_halted", halted, 1);
        halt_v = 0; btn_v = 1;
        run(20);
        btn_v = 0;
        run(250);
        check("halt_pulses", pulses - p0, 0);
        check("halt_hold_state", run_state, M_HALT);
        sw_v = 0;
        run(2);
        check("halt_wait_sync", run_state, M_HALT);
        run(1);
        check("halt_exit", run_state, M_IDLE);
        run(10);

        // Bouncy step button then held
        p0 = pulses; c0 = m_cnt;
        btn_v = 1; run(1); btn_v = 0; run(1); btn_v = 1; run(1);
        run(500);
        check("bouncy_pulses", pulses - p0, 1);
        check("bouncy_cnt", instr_cnt, (c0 + 1) % 16);
        check("bouncy_state", run_state, M_IDLE);
        btn_v = 0;
        run(20);

        // Reset asserted while cpu_en is high
        sw_v = 1; found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc();
            if (cpu_en === 1'b1) found = 1;
        end
        check("reset_found_pulse", found, 1);
        reset_now();
        p0 = pulses;
        run(300);
        check("post_reset_state", run_state, M_RUN);
        sw_v = 0;
        run(10);

        // Counter wrap over 17 single steps
        reset_now();
        for (s = 1; s <= 17; s++) begin
            btn_v = 1; run(12);
            btn_v = 0; run(120);
            check($sformatf("wrap_step%0d", s), instr_cnt, s % 16);
        end

        // Randomised phases against the model
        for (int k = 0; k < 60; k++) begin
            sw_v   = 1'($urandom_range(0, 1));
            btn_v  = 1'($urandom_range(0, 1));
            halt_v = ($urandom_range(0, 3) == 0);
            run($urandom_range(1, 150));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
